// File: rtl/tc_arb_pkg.sv
// Shared types and constants for the 4-way round-robin decoder arbiter.
// The optional hold-timeout (TC_ARB_TIMEOUT_EN) uses HOLD_W from here.
package tc_arb_pkg;

    localparam int unsigned N_REQ  = 4;
    localparam int unsigned IDX_W  = 2;
    localparam int unsigned HOLD_W = 8;

    typedef enum logic [0:0] {
        ARB_IDLE,
        ARB_GRANT
    } arb_state_t;

endpackage

// File: rtl/tc_rr_pick4.sv
// Combinational round-robin picker: first asserted request after ptr,
// searching ptr+1 .. ptr+4 cyclically.
module tc_rr_pick4
    import tc_arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic             hit,
    output logic [IDX_W-1:0] idx
);

    logic [IDX_W-1:0] w_cand;

    // Walk from the farthest candidate back to the nearest so the closest hit wins.
    always_comb begin
        hit    = 1'b0;
        idx    = ptr;
        w_cand = ptr;
        for (int k = N_REQ; k >= 1; k--) begin
            w_cand = ptr + IDX_W'(k);
            if (req[w_cand]) begin
                hit = 1'b1;
                idx = w_cand;
            end
        end
    end

endmodule

// File: rtl/tc_decoder_arbiter4.sv
// Round-robin arbiter driving a 2-to-4 decoder select with break-before-make.
// Define TC_ARB_TIMEOUT_EN to force release after MAX_HOLD grant cycles.
module tc_decoder_arbiter4
    import tc_arb_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic             done,
    output logic [N_REQ-1:0] grant,
    output logic             sel0,
    output logic             sel1,
    output logic             busy,
    output logic             timeout
);

    localparam logic [HOLD_W-1:0] LP_HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

    arb_state_t       r_state, w_state_d;
    logic [IDX_W-1:0] r_ptr, w_ptr_d;
    logic [IDX_W-1:0] r_owner, w_owner_d;
    logic             r_timeout, w_timeout_d;
    logic             w_hit;
    logic [IDX_W-1:0] w_idx;
    logic             w_release;

    tc_rr_pick4 u_pick (
        .req (req),
        .ptr (r_ptr),
        .hit (w_hit),
        .idx (w_idx)
    );

    assign w_release = done | ~req[r_owner];

`ifdef TC_ARB_TIMEOUT_EN
    logic [HOLD_W-1:0] r_hold, w_hold_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_hold <= '0;
        else     r_hold <= w_hold_d;
    end
`else
    logic w_unused_hold;
    assign w_unused_hold = ^LP_HOLD_LAST;
`endif

    always_comb begin
        w_state_d   = r_state;
        w_ptr_d     = r_ptr;
        w_owner_d   = r_owner;
        w_timeout_d = 1'b0;
`ifdef TC_ARB_TIMEOUT_EN
        w_hold_d    = r_hold;
`endif
        unique case (r_state)
            ARB_IDLE: begin
                if (w_hit) begin
                    w_state_d = ARB_GRANT;
                    w_ptr_d   = w_idx;
                    w_owner_d = w_idx;
`ifdef TC_ARB_TIMEOUT_EN
                    w_hold_d  = '0;
`endif
                end
            end
            ARB_GRANT: begin
                if (w_release) begin
                    w_state_d = ARB_IDLE;
`ifdef TC_ARB_TIMEOUT_EN
                end else if (r_hold == LP_HOLD_LAST) begin
                    // ptr already points at this owner, so it ranks last next time.
                    w_state_d   = ARB_IDLE;
                    w_timeout_d = 1'b1;
                end else begin
                    w_hold_d = r_hold + 1'b1;
`endif
                end
            end
            default: w_state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ARB_IDLE;
            r_ptr     <= IDX_W'(N_REQ - 1);
            r_owner   <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_state_d;
            r_ptr     <= w_ptr_d;
            r_owner   <= w_owner_d;
            r_timeout <= w_timeout_d;
        end
    end

    assign busy    = (r_state == ARB_GRANT);
    assign grant   = busy ? (N_REQ'(1) << r_owner) : '0;
    assign sel0    = r_owner[0];
    assign sel1    = r_owner[1];
    assign timeout = r_timeout;

endmodule

// File: tb/tb_tc_decoder_arbiter4.sv
// Directed self-checking bench for tc_decoder_arbiter4.
// Timeout scenario is exercised only when TC_ARB_TIMEOUT_EN is defined.
module tb_tc_decoder_arbiter4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req = 4'b0000;
    logic       done = 1'b0;
    logic [3:0] grant;
    logic       sel0, sel1, busy, timeout;

    int checks = 0;
    int errors = 0;

    tc_decoder_arbiter4 #(.MAX_HOLD(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .done    (done),
        .grant   (grant),
        .sel0    (sel0),
        .sel1    (sel1),
        .busy    (busy),
        .timeout (timeout)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req  = 4'b0000;
        done = 1'b0;
        rst  = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        checks++;
        if ({grant, sel1, sel0, busy, timeout} !== 8'b0000_00_0_0) begin
            errors++;
            $display("FAIL reset: got grant=%b sel=%b%b busy=%b timeout=%b, want 0000 00 0 0",
                     grant, sel1, sel0, busy, timeout);
        end
        do_reset();
    endtask

    task automatic test_single();
        do_reset();
        req = 4'b0001;
        tick();
        checks++;
        if ({grant, sel1, sel0, busy} !== 7'b0001_00_1) begin
            errors++;
            $display("FAIL single_grant: got grant=%b sel=%b%b busy=%b, want 0001 00 1",
                     grant, sel1, sel0, busy);
        end
        req  = 4'b0000;
        done = 1'b1;
        tick();
        checks++;
        if ({grant, busy} !== 5'b0000_0) begin
            errors++;
            $display("FAIL single_release: got grant=%b busy=%b, want 0000 0", grant, busy);
        end
        done = 1'b0;
        // done while idle must not do anything
        done = 1'b1;
        tick();
        checks++;
        if ({grant, busy} !== 5'b0000_0) begin
            errors++;
            $display("FAIL done_idle: got grant=%b busy=%b, want 0000 0", grant, busy);
        end
        done = 1'b0;
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_g [9];
        logic [1:0] exp_s [9];
        exp_g = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100, 4'b0000, 4'b1000, 4'b0000, 4'b0001};
        exp_s = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3, 2'd0};
        do_reset();
        req  = 4'b1111;
        done = 1'b1;
        for (int i = 0; i < 9; i++) begin
            tick();
            checks++;
            if (grant !== exp_g[i] || {sel1, sel0} !== exp_s[i] || busy !== (exp_g[i] != 4'b0)) begin
                errors++;
                $display("FAIL round_robin[%0d]: got grant=%b sel=%b%b busy=%b, want %b %b",
                         i, grant, sel1, sel0, busy, exp_g[i], exp_s[i]);
            end
        end
        req  = 4'b0000;
        done = 1'b0;
    endtask

    task automatic test_same_cycle();
        do_reset();
        req = 4'b0100;
        tick();
        checks++;
        if (grant !== 4'b0100 || {sel1, sel0} !== 2'b10) begin
            errors++;
            $display("FAIL same_cycle_owner2: got grant=%b sel=%b%b, want 0100 10", grant, sel1, sel0);
        end
        req  = 4'b0110;
        done = 1'b1;
        tick();
        checks++;
        if (grant !== 4'b0000 || busy !== 1'b0 || {sel1, sel0} !== 2'b10) begin
            errors++;
            $display("FAIL same_cycle_idle: got grant=%b busy=%b sel=%b%b, want 0000 0 10",
                     grant, busy, sel1, sel0);
        end
        done = 1'b0;
        tick();
        checks++;
        if (grant !== 4'b0010 || {sel1, sel0} !== 2'b01) begin
            errors++;
            $display("FAIL same_cycle_next: got grant=%b sel=%b%b, want 0010 01", grant, sel1, sel0);
        end
        req = 4'b0000;
    endtask

    task automatic test_back_to_back();
        do_reset();
        req  = 4'b1000;
        done = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++;
            if (grant !== ((i % 2 == 0) ? 4'b1000 : 4'b0000)) begin
                errors++;
                $display("FAIL back_to_back[%0d]: got grant=%b, want %b",
                         i, grant, (i % 2 == 0) ? 4'b1000 : 4'b0000);
            end
        end
        req  = 4'b0000;
        done = 1'b0;
    endtask

    task automatic test_non_owner_change();
        do_reset();
        req = 4'b0001;
        tick();
        req = 4'b1111;
        tick();
        tick();
        checks++;
        if (grant !== 4'b0001 || {sel1, sel0} !== 2'b00) begin
            errors++;
            $display("FAIL non_owner_change: got grant=%b sel=%b%b, want 0001 00", grant, sel1, sel0);
        end
        req = 4'b0000;
    endtask

    task automatic test_timeout();
`ifdef TC_ARB_TIMEOUT_EN
        do_reset();
        req = 4'b0011;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (grant !== 4'b0001 || timeout !== 1'b0) begin
                errors++;
                $display("FAIL timeout_hold[%0d]: got grant=%b timeout=%b, want 0001 0",
                         i, grant, timeout);
            end
        end
        tick();
        checks++;
        if (grant !== 4'b0000 || timeout !== 1'b1) begin
            errors++;
            $display("FAIL timeout_pulse: got grant=%b timeout=%b, want 0000 1", grant, timeout);
        end
        tick();
        checks++;
        if (grant !== 4'b0010 || timeout !== 1'b0) begin
            errors++;
            $display("FAIL timeout_next: got grant=%b timeout=%b, want 0010 0", grant, timeout);
        end
`else
        do_reset();
        req = 4'b0011;
        for (int i = 0; i < 20; i++) begin
            tick();
            checks++;
            if (grant !== 4'b0001 || timeout !== 1'b0) begin
                errors++;
                $display("FAIL no_timeout[%0d]: got grant=%b timeout=%b, want 0001 0",
                         i, grant, timeout);
            end
        end
`endif
        req = 4'b0000;
    endtask

    task automatic test_reset_mid_grant();
        do_reset();
        req = 4'b0100;
        tick();
        checks++;
        if (grant !== 4'b0100) begin
            errors++;
            $display("FAIL mid_reset_setup: got grant=%b, want 0100", grant);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({grant, sel1, sel0, busy, timeout} !== 8'b0000_00_0_0) begin
            errors++;
            $display("FAIL mid_reset_async: got grant=%b sel=%b%b busy=%b timeout=%b, want 0000 00 0 0",
                     grant, sel1, sel0, busy, timeout);
        end
        tick();
        rst = 1'b0;
        req = 4'b1111;
        tick();
        checks++;
        if (grant !== 4'b0001 || {sel1, sel0} !== 2'b00) begin
            errors++;
            $display("FAIL mid_reset_ptr: got grant=%b sel=%b%b, want 0001 00", grant, sel1, sel0);
        end
        req = 4'b0000;
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_same_cycle();
        test_back_to_back();
        test_non_owner_change();
        test_timeout();
        test_reset_mid_grant();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
